i2c_target: RTL and testbench

- Single-address I2C target (slave) byte engine; the responder end of the team's I2C master byte engine.
- Oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit address and ACKs it.
- Delivers write bytes to a local register/FIFO interface; fetches read bytes from it on request.
- No clock stretching, no general call, no 10-bit addressing; standard/fast-mode with clk ≥ 20× SCL.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_sync_edge.sv | 43 ++++
 rtl/i2c_target.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target byte engine.
//   i2c_state_e : byte-engine states
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//   RW_READ : value of the R/W bit that selects a read transfer
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop for one asynchronous bus line.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous pad input
//   lvl      : synchronized level
//   rise     : one-cycle pulse on a 0->1 transition of lvl
//   fall     : one-cycle pulse on a 1->0 transition of lvl
// Flops reset to the idle bus level so that reset never fakes an edge.
module i2c_sync_edge
  import i2c_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      hist_p2 <= RST_VAL;
    end else begin
      // p0/p1: metastability filter
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      // p2: previous synchronized level for edge detection
      hist_p2 <= sync_p1;
    end
  end

  assign lvl  = sync_p1;
  assign rise = sync_p1 & ~hist_p2;
  assign fall = ~sync_p1 & hist_p2;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target byte engine (no clock stretching).
//   clk, rst        : system clock, synchronous active-high reset
//   scl_i, sda_i    : asynchronous pad inputs
//   scl_o           : SCL open-drain drive, always released
//   sda_o           : SDA open-drain drive (0 = pull low, 1 = release)
//   wr_valid/wr_data/wr_first : received write byte strobe, data, first-after-address flag
//   rd_req/rd_data  : read byte request pulse; rd_data sampled one clk after rd_req
//   start_det/stop_det : START (incl. repeated) / STOP pulses
//   busy            : addressed and active until STOP, START or read NACK
//   nack_rx         : master NACKed a read byte
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       wr_first,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       nack_rx
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk  (clk),
    .rst  (rst),
    .d    (scl_i),
    .lvl  (scl_s),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk  (clk),
    .rst  (rst),
    .d    (sda_i),
    .lvl  (sda_s),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_s;
  assign stop_c  = sda_rise & scl_s;

  // Registered control
  i2c_state_e       state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             byte_done, byte_done_n;   // 8 bits taken (or ACK seen), waiting for scl_fall
  logic             rw, rw_n;
  logic             busy_n;
  logic             first, first_n;           // next write byte is the first after the address
  logic             rd_load;                  // rd_req delayed one cycle: capture rd_data now
  logic             pend_vld, pend_val;
  logic [CNT_W-1:0] pend_cnt;

  // Combinational strobes
  logic       shift, arm, arm_val, rel_now, wr_strobe;
  logic       wr_valid_n, rd_req_n, start_n, stop_n, nack_n;

  // Data
  logic [7:0] sr;
  logic [7:0] rx_byte;
  assign rx_byte = {sr[6:0], sda_s};

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_done_n = byte_done;
    rw_n        = rw;
    busy_n      = busy;
    first_n     = first;
    shift       = 1'b0;
    arm         = 1'b0;
    arm_val     = I2C_NACK;
    rel_now     = 1'b0;
    wr_strobe   = 1'b0;
    wr_valid_n  = 1'b0;
    rd_req_n    = 1'b0;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    nack_n      = 1'b0;

    if (start_c) begin
      state_n     = S_ADDR;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
      busy_n      = 1'b0;
      rel_now     = 1'b1;
      start_n     = 1'b1;
    end else if (stop_c) begin
      state_n     = S_IDLE;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
      busy_n      = 1'b0;
      rel_now     = 1'b1;
      stop_n      = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise && !byte_done) begin
            shift     = 1'b1;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == ADDR) begin
                rw_n        = rx_byte[0];
                busy_n      = 1'b1;
                first_n     = 1'b1;
                byte_done_n = 1'b1;
              end else begin
                state_n = S_WAIT_STOP;
              end
            end
          end else if (scl_fall && byte_done) begin
            arm         = 1'b1;
            arm_val     = I2C_ACK;
            byte_done_n = 1'b0;
            state_n     = S_ADDR_ACK;
          end
        end

        S_ADDR_ACK: begin
          if (scl_rise && rw == RW_READ) begin
            rd_req_n = 1'b1;
          end
          if (scl_fall) begin
            arm = 1'b1;
            if (rw == RW_READ) begin
              arm_val = sr[7];
              state_n = S_RD_DATA;
            end else begin
              arm_val = I2C_NACK;
              state_n = S_WR_DATA;
            end
          end
        end

        S_WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shift     = 1'b1;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_valid_n  = 1'b1;
              wr_strobe   = 1'b1;
              first_n     = 1'b0;
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            arm         = 1'b1;
            arm_val     = I2C_ACK;
            byte_done_n = 1'b0;
            state_n     = S_WR_ACK;
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            arm     = 1'b1;
            arm_val = I2C_NACK;
            state_n = S_WR_DATA;
          end
        end

        // sr[7] already went out on the entering fall; each later fall
        // presents sr[6] and shifts, the eighth releases for the ACK slot.
        S_RD_DATA: begin
          if (scl_fall) begin
            arm       = 1'b1;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              arm_val = I2C_NACK;
              state_n = S_RD_ACK;
            end else begin
              arm_val = sr[6];
              shift   = 1'b1;
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise && !byte_done) begin
            if (sda_s == I2C_NACK) begin
              nack_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = S_WAIT_STOP;
            end else begin
              rd_req_n    = 1'b1;
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            arm         = 1'b1;
            arm_val     = sr[7];
            byte_done_n = 1'b0;
            state_n     = S_RD_DATA;
          end
        end

        S_WAIT_STOP: ;

        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      first     <= 1'b0;
      rd_load   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= 8'h00;
      wr_first  <= 1'b0;
      rd_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      nack_rx   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_done <= byte_done_n;
      rw        <= rw_n;
      busy      <= busy_n;
      first     <= first_n;
      rd_load   <= rd_req;
      wr_valid  <= wr_valid_n;
      rd_req    <= rd_req_n;
      start_det <= start_n;
      stop_det  <= stop_n;
      nack_rx   <= nack_n;
      if (wr_strobe) begin
        wr_data  <= rx_byte;
        wr_first <= first;
      end
    end
  end

  // SDA updates only through a pending slot armed by scl_fall, so the drive
  // always changes HOLD_CYC cycles into SCL low. START/STOP release at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_o    <= 1'b1;
      pend_vld <= 1'b0;
      pend_val <= 1'b1;
      pend_cnt <= '0;
    end else if (rel_now) begin
      sda_o    <= 1'b1;
      pend_vld <= 1'b0;
    end else if (arm) begin
      pend_vld <= 1'b1;
      pend_val <= arm_val;
      pend_cnt <= CNT_W'(HOLD_CYC - 1);
    end else if (pend_vld) begin
      if (pend_cnt == '0) begin
        sda_o    <= pend_val;
        pend_vld <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_load) begin
      sr <= rd_data;
    end else if (shift) begin
      sr <= rx_byte;
    end
  end

  assign scl_o = 1'b1;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  localparam logic [6:0] TADDR = 7'h50;
  localparam int         HOLD  = 4;
  localparam int         Q     = 8;   // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_o, sda_o, wr_valid, wr_first, rd_req;
  logic       start_det, stop_det, busy, nack_rx;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic       scl_bus, sda_bus;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(TADDR), .HOLD_CYC(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_bus),
    .sda_i     (sda_bus),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_first  (wr_first),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy),
    .nack_rx   (nack_rx)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected write deliveries and bytes the local side serves.
  typedef struct packed {logic first; logic [7:0] data;} wr_t;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] tx_buf [4];

  int   cnt_start = 0, cnt_stop = 0, cnt_rdreq = 0, cnt_nack = 0, cnt_wr = 0;
  logic prev_sda_o = 1'b1;
  logic [7:0] last_wr = 8'h00;

  // Per-cycle compare process plus the local read-data provider.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (start_det) cnt_start++;
      if (stop_det)  cnt_stop++;
      if (nack_rx)   cnt_nack++;
      if (rd_req) begin
        cnt_rdreq++;
        rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
      end
      if (wr_valid) begin
        cnt_wr++;
        last_wr = wr_data;
        if (wr_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL wr_unexpected: got wr_valid data %0h, expected no write", wr_data);
        end else begin
          e = wr_q.pop_front();
          chk("wr_data", {24'h0, wr_data}, {24'h0, e.data});
          chk("wr_first", {31'h0, wr_first}, {31'h0, e.first});
        end
      end
      if (sda_o !== prev_sda_o) chk("sda_change_scl_low", {31'h0, scl_m}, 32'h0);
    end
    prev_sda_o = sda_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    logic [7:0] v;
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_in(x);
      v[i] = x;
    end
    b = v;
    bit_out(ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sda_o"},     {31'h0, sda_o},     32'h1);
    chk({tag, "_scl_o"},     {31'h0, scl_o},     32'h1);
    chk({tag, "_wr_valid"},  {31'h0, wr_valid},  32'h0);
    chk({tag, "_wr_data"},   {24'h0, wr_data},   32'h0);
    chk({tag, "_wr_first"},  {31'h0, wr_first},  32'h0);
    chk({tag, "_rd_req"},    {31'h0, rd_req},    32'h0);
    chk({tag, "_start_det"}, {31'h0, start_det}, 32'h0);
    chk({tag, "_stop_det"},  {31'h0, stop_det},  32'h0);
    chk({tag, "_busy"},      {31'h0, busy},      32'h0);
    chk({tag, "_nack_rx"},   {31'h0, nack_rx},   32'h0);
  endtask

  // Write transaction: address a, n bytes from tx_buf.
  task automatic do_write(input logic [6:0] a, input int n, input bit with_stop);
    logic ack;
    logic match;
    wr_t  e;
    int   s0, p0, r0, w0;
    match = (a == TADDR);
    s0 = cnt_start; p0 = cnt_stop; r0 = cnt_rdreq; w0 = cnt_wr;
    m_start();
    send_byte({a, 1'b0}, ack);
    chk("wr_addr_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
    for (int i = 0; i < n; i++) begin
      if (match) begin
        e.first = (i == 0);
        e.data  = tx_buf[i];
        wr_q.push_back(e);
      end
      send_byte(tx_buf[i], ack);
      chk("wr_data_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
      if (i == 0) chk("busy_in_write", {31'h0, busy}, {31'h0, match});
    end
    chk("wr_count", cnt_wr - w0, match ? n : 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("wr_start_count", cnt_start - s0, 1);
    chk("wr_rd_req_count", cnt_rdreq - r0, 0);
    if (with_stop) begin
      m_stop();
      chk("wr_stop_count", cnt_stop - p0, 1);
      chk("busy_after_stop", {31'h0, busy}, 32'h0);
    end else begin
      chk("wr_no_stop", cnt_stop - p0, 0);
    end
  endtask

  // Read transaction: address a, n bytes served from tx_buf, last one NACKed.
  task automatic do_read(input logic [6:0] a, input int n, input bit with_stop);
    logic       ack;
    logic       match;
    logic [7:0] v;
    int         s0, p0, r0, k0, w0;
    match = (a == TADDR);
    rd_q.delete();
    if (match) for (int i = 0; i < n; i++) rd_q.push_back(tx_buf[i]);
    s0 = cnt_start; p0 = cnt_stop; r0 = cnt_rdreq; k0 = cnt_nack; w0 = cnt_wr;
    m_start();
    send_byte({a, 1'b1}, ack);
    chk("rd_addr_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
    for (int i = 0; i < n; i++) begin
      recv_byte(v, (i == n - 1));
      chk("rd_byte", {24'h0, v}, match ? {24'h0, tx_buf[i]} : 32'hFF);
    end
    chk("rd_req_count", cnt_rdreq - r0, match ? n : 0);
    chk("nack_count", cnt_nack - k0, match ? 1 : 0);
    chk("busy_after_nack", {31'h0, busy}, 32'h0);
    chk("sda_released", {31'h0, sda_o}, 32'h1);
    chk("rd_wr_count", cnt_wr - w0, 0);
    chk("rd_start_count", cnt_start - s0, 1);
    chk("rd_no_stop_yet", cnt_stop - p0, 0);
    if (with_stop) begin
      m_stop();
      chk("rd_stop_count", cnt_stop - p0, 1);
    end
  endtask

  initial begin
    logic       ack;
    logic [6:0] a;
    int         n, s0, p0, w0;

    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(4);

    // Directed write: 0x12 (first), 0x34.
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h34;
    do_write(TADDR, 2, 1);
    chk("lit_last_wr", {24'h0, last_wr}, 32'h34);

    // Address mismatch: 0xA2 then 0x55.
    tx_buf[0] = 8'h55;
    do_write(7'h51, 1, 1);

    // Directed read: 0xC3 ACKed, 0x5A NACKed.
    tx_buf[0] = 8'hC3; tx_buf[1] = 8'h5A;
    do_read(TADDR, 2, 1);

    // Repeated start: write 0x07, Sr, read one byte, STOP.
    s0 = cnt_start; p0 = cnt_stop;
    tx_buf[0] = 8'h07;
    do_write(TADDR, 1, 0);
    chk("lit_sr_wr", {24'h0, last_wr}, 32'h07);
    tx_buf[0] = 8'h9E;
    do_read(TADDR, 1, 1);
    chk("sr_start_count", cnt_start - s0, 2);
    chk("sr_stop_count", cnt_stop - p0, 1);

    // Abort after four bits of a write byte.
    w0 = cnt_wr; p0 = cnt_stop;
    m_start();
    send_byte({TADDR, 1'b0}, ack);
    chk("abort_addr_ack", {31'h0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) bit_out(i[0]);
    m_stop();
    chk("abort_no_wr", cnt_wr - w0, 0);
    chk("abort_stop", cnt_stop - p0, 1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C; tx_buf[2] = 8'hFF;
    do_write(TADDR, 3, 1);

    // Reset while the address ACK is being driven.
    m_start();
    for (int i = 7; i >= 0; i--) bit_out(i == 7 || i == 5);
    sda_m = 1'b1;
    tick(Q);
    chk("ack_driven", {31'h0, sda_o}, 32'h0);
    chk("ack_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midack_reset");
    rst = 1'b0;
    tick(2);
    m_stop();
    tx_buf[0] = 8'h42;
    do_write(TADDR, 1, 1);

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      a = ($urandom_range(0, 3) == 0) ? (TADDR ^ 7'($urandom_range(1, 127))) : TADDR;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, n, 1);
      else                           do_read(a, n, 1);
    end

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
